uart_cmd_sequencer: RTL
=======================

Name: uart_cmd_sequencer

Overview:
Frame-level controller placed after the UART receiver. It consumes received bytes and parity flags, hunts for a sync byte, and parses a framed write command of address, length, payload and checksum. Payload is buffered and released to the core register/config bus only after the checksum verifies, one byte per ready/valid beat. It is the single host path for configuring the core over serial.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
ADDR_W, 8, register address width; frame address byte is zero-extended to ADDR_W
MAX_LEN, 16, payload buffer depth in bytes (power of two, 2..64)
TIMEOUT_CYCLES, 100000, inter-byte timeout in clk cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rxData  in  8  received byte from the UART receiver
rxValid  in  1  one-cycle strobe; rxData/rxParityError valid this cycle
rxParityError  in  1  parity error flag for the current byte
wrValid  out  1  register write request
wrAddr  out  ADDR_W  write address
wrData  out  8  write data
wrReady  in  1  bus accepts the beat when wrValid && wrReady
busy  out  1  high in every state except HUNT
frameDone  out  1  one-cycle pulse after the last beat of a frame is accepted
frameError  out  1  one-cycle pulse on frame abort or overrun
errCode  out  3  last error: 0 none, 1 parity, 2 length, 3 checksum, 4 overrun, 5 timeout; holds until next error
errCount  out  8  saturating count of frameError pulses (stops at 255)

Behaviour:
- Reset (async, active-high): state HUNT; wrValid, frameDone, frameError, busy = 0; errCode = 0; errCount = 0; wrAddr, wrData = 0; buffer contents don't-care. Reset mid-frame discards the frame with no pulses.
- A byte is consumed only on a cycle with rxValid=1. All outputs are registered.
- Frame format: SYNC, ADDR, LEN, D[0..LEN-1], CHK. CHK = XOR of ADDR, LEN and all D bytes.
- HUNT: on rxValid, a byte equal to SYNC_BYTE with no parity error -> ADDR. All other bytes, including bytes with parity errors, are ignored silently.
- ADDR: latch the base address and seed the checksum with it -> LEN.
- LEN: LEN==0 or LEN>MAX_LEN -> abort with code 2. Otherwise latch LEN, fold it into the checksum, clear idx -> PAYLOAD.
- PAYLOAD: write buf[idx] and fold the byte into the checksum. idx==LEN-1 -> CHECK, else idx++. SYNC_BYTE values inside a frame are treated as plain data; there is no resync.
- CHECK: rxData==checksum -> COMMIT with idx=0; mismatch -> abort with code 3.
- Parity error in any of ADDR/LEN/PAYLOAD/CHECK -> abort with code 1. This takes priority over length and checksum errors on the same byte.
- Abort: next cycle frameError=1, errCode updated, errCount incremented, state HUNT. No write is issued for an aborted frame.
- COMMIT: wrValid=1, wrAddr=base+idx (wraps modulo 2^ADDR_W), wrData=buf[idx]. On wrValid&&wrReady: if idx==LEN-1 -> DONE, else idx++ and the next beat is presented on the following cycle. wrAddr/wrData are held stable while wrValid && !wrReady.
- DONE: frameDone=1 for one cycle -> HUNT. Back-to-back frames: a SYNC byte arriving in the DONE cycle is dropped as overrun.
- Overrun: rxValid in COMMIT or DONE drops the byte and pulses frameError with code 4. The in-progress commit continues unaffected; frameDone still fires.
- Worst-case write latency: the first wrValid rises one cycle after the CHK byte's rxValid cycle.

Optional Feature:
UART_CMD_TIMEOUT_EN
- Defined: a timeout counter clears on every rxValid and in HUNT/COMMIT/DONE, and counts in ADDR/LEN/PAYLOAD/CHECK. Reaching TIMEOUT_CYCLES-1 with no byte aborts the frame with code 5. If the timeout and an rxValid occur in the same cycle, the byte wins.
- Undefined: no counter exists; a partial frame waits indefinitely; code 5 never occurs.

Decomposition:
- Shared package uart_cmd_pkg: the state enum (HUNT, ADDR, LEN, PAYLOAD, CHECK, COMMIT, DONE), the errCode enum, and the SYNC_BYTE default. The receiver testbench reuses the package.
- One sub-module: uart_cmd_buffer, a MAX_LEN x 8 register array with one synchronous write port and one asynchronous read port, indexed by idx.

Test Plan:
- Frame A5 10 02 11 22 CHK=0x21, wrReady=1 -> writes (0x10,0x11) then (0x11,0x22) on consecutive cycles, then one frameDone pulse; errCount stays 0.
- Same frame with CHK=0x20 -> no wrValid; frameError with errCode=3; errCount=1; busy=0 afterwards.
- Frame with LEN=0x00, and separately LEN=MAX_LEN+1 -> abort with errCode=2 on the LEN byte; the next valid frame commits correctly.
- Parity error on D[0] -> errCode=1, no writes. A parity-error byte of value 0xA5 while in HUNT -> ignored, busy stays 0.
- wrReady low for 3 cycles on the second beat of a valid 4-byte frame at base 0xFE -> wrAddr/wrData held stable; addresses issued FE, FF, 00, 01; one rxValid during COMMIT gives errCode=4 and all 4 writes still complete.
- With UART_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=50: stop after the LEN byte -> frameError with errCode=5 at cycle 50; without the macro, busy stays high indefinitely.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types for the UART command sequencer: FSM states, error codes and the default sync byte.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    ADDR    = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CHECK   = 3'd4,
    COMMIT  = 3'd5,
    DONE    = 3'd6
  } seq_state_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_PARITY   = 3'd1,
    ERR_LENGTH   = 3'd2,
    ERR_CHECKSUM = 3'd3,
    ERR_OVERRUN  = 3'd4,
    ERR_TIMEOUT  = 3'd5
  } err_code_e;

endpackage

// File: rtl/uart_cmd_buffer.sv
// Payload buffer: DEPTH x 8 registers, synchronous write, asynchronous read.
module uart_cmd_buffer #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wrIdx,
  input  logic [7:0]       i_wrData,
  input  logic [IDX_W-1:0] i_rdIdx,
  output logic [7:0]       o_rdData
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wrIdx] <= i_wrData;
  end

  assign o_rdData = r_mem[i_rdIdx];

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Frame parser after the UART receiver: SYNC, ADDR, LEN, D[], CHK -> buffered register writes.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         ADDR_W         = 8,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rxData,
  input  logic              rxValid,
  input  logic              rxParityError,
  output logic              wrValid,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [7:0]        wrData,
  input  logic              wrReady,
  output logic              busy,
  output logic              frameDone,
  output logic              frameError,
  output logic [2:0]        errCode,
  output logic [7:0]        errCount
);

  localparam int IDX_W = $clog2(MAX_LEN);

  seq_state_e        r_state, w_stateNext;
  logic [IDX_W-1:0]  r_idx, w_idxNext;
  logic [IDX_W-1:0]  r_lenM1, w_lenM1Next;
  logic [ADDR_W-1:0] r_base, w_baseNext;
  logic [7:0]        r_chk, w_chkNext;
  logic              w_bufWe, w_err;
  err_code_e         w_errCode;
  logic [7:0]        w_rdData;

  logic              r_wrValid, r_busy, r_frameDone, r_frameError;
  logic [ADDR_W-1:0] r_wrAddr;
  logic [7:0]        r_wrData, r_errCount;
  err_code_e         r_errCode;

  // Read port follows the next index so the registered beat is ready on entry to COMMIT.
  uart_cmd_buffer #(.DEPTH(MAX_LEN), .IDX_W(IDX_W)) u_buf (
    .clk      (clk),
    .i_we     (w_bufWe),
    .i_wrIdx  (r_idx),
    .i_wrData (rxData),
    .i_rdIdx  (w_idxNext),
    .o_rdData (w_rdData)
  );

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] r_toCnt;
  logic            w_inFrame, w_timeout;

  assign w_inFrame = (r_state == ADDR) || (r_state == LEN) ||
                     (r_state == PAYLOAD) || (r_state == CHECK);
  assign w_timeout = w_inFrame && !rxValid && (r_toCnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               r_toCnt <= '0;
    else if (rxValid || !w_inFrame || w_timeout) r_toCnt <= '0;
    else                                     r_toCnt <= r_toCnt + TO_W'(1);
  end
`endif

  always_comb begin
    w_stateNext = r_state;
    w_idxNext   = r_idx;
    w_lenM1Next = r_lenM1;
    w_baseNext  = r_base;
    w_chkNext   = r_chk;
    w_bufWe     = 1'b0;
    w_err       = 1'b0;
    w_errCode   = ERR_NONE;
    unique case (r_state)
      HUNT: if (rxValid && !rxParityError && rxData == SYNC_BYTE) w_stateNext = ADDR;
      ADDR, LEN, PAYLOAD, CHECK: if (rxValid) begin
        if (rxParityError) begin
          w_stateNext = HUNT; w_err = 1'b1; w_errCode = ERR_PARITY;
        end else if (r_state == ADDR) begin
          w_baseNext  = ADDR_W'(rxData);
          w_chkNext   = rxData;
          w_stateNext = LEN;
        end else if (r_state == LEN) begin
          if (rxData == 8'd0 || rxData > 8'(MAX_LEN)) begin
            w_stateNext = HUNT; w_err = 1'b1; w_errCode = ERR_LENGTH;
          end else begin
            w_lenM1Next = IDX_W'(rxData - 8'd1);
            w_chkNext   = r_chk ^ rxData;
            w_idxNext   = '0;
            w_stateNext = PAYLOAD;
          end
        end else if (r_state == PAYLOAD) begin
          w_bufWe   = 1'b1;
          w_chkNext = r_chk ^ rxData;
          if (r_idx == r_lenM1) w_stateNext = CHECK;
          else                  w_idxNext   = r_idx + IDX_W'(1);
        end else if (rxData == r_chk) begin
          w_idxNext   = '0;
          w_stateNext = COMMIT;
        end else begin
          w_stateNext = HUNT; w_err = 1'b1; w_errCode = ERR_CHECKSUM;
        end
      end
      COMMIT: begin
        if (r_wrValid && wrReady) begin
          if (r_idx == r_lenM1) w_stateNext = DONE;
          else                  w_idxNext   = r_idx + IDX_W'(1);
        end
        if (rxValid) begin w_err = 1'b1; w_errCode = ERR_OVERRUN; end
      end
      DONE: begin
        w_stateNext = HUNT;
        if (rxValid) begin w_err = 1'b1; w_errCode = ERR_OVERRUN; end
      end
      default: w_stateNext = HUNT;
    endcase
`ifdef UART_CMD_TIMEOUT_EN
    if (w_timeout) begin
      w_stateNext = HUNT; w_err = 1'b1; w_errCode = ERR_TIMEOUT;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= HUNT;
      r_idx        <= '0;
      r_lenM1      <= '0;
      r_base       <= '0;
      r_chk        <= '0;
      r_wrValid    <= 1'b0;
      r_wrAddr     <= '0;
      r_wrData     <= '0;
      r_busy       <= 1'b0;
      r_frameDone  <= 1'b0;
      r_frameError <= 1'b0;
      r_errCode    <= ERR_NONE;
      r_errCount   <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_idx        <= w_idxNext;
      r_lenM1      <= w_lenM1Next;
      r_base       <= w_baseNext;
      r_chk        <= w_chkNext;
      r_wrValid    <= (w_stateNext == COMMIT);
      if (w_stateNext == COMMIT) begin
        r_wrAddr <= r_base + ADDR_W'(w_idxNext);
        r_wrData <= w_rdData;
      end
      r_busy       <= (w_stateNext != HUNT);
      r_frameDone  <= (w_stateNext == DONE);
      r_frameError <= w_err;
      if (w_err) begin
        r_errCode <= w_errCode;
        if (r_errCount != '1) r_errCount <= r_errCount + 8'd1;
      end
    end
  end

  assign wrValid    = r_wrValid;
  assign wrAddr     = r_wrAddr;
  assign wrData     = r_wrData;
  assign busy       = r_busy;
  assign frameDone  = r_frameDone;
  assign frameError = r_frameError;
  assign errCode    = r_errCode;
  assign errCount   = r_errCount;

endmodule
